// File: rtl/core_pkg.sv
// Shared core types: immediate-source select, opcode class, fetch FSM state.
package core_pkg;

    localparam int unsigned INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        IMM_DP8   = 2'd0,
        IMM_MEM12 = 2'd1,
        IMM_BR24  = 2'd2
    } imm_src_t;

    typedef enum logic [1:0] {
        OP_DP    = 2'd0,
        OP_MEM   = 2'd1,
        OP_BR    = 2'd2,
        OP_UNDEF = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_imm_src_decode.sv
// Combinational decode of the instruction op field into the extend-stage
// immediate select plus an undefined-op flag.
module imm_src_decode
    import core_pkg::*;
(
    input  logic [1:0] i_op,
    output logic [1:0] o_imm_src,
    output logic       o_undef
);

    always_comb begin
        o_imm_src = IMM_DP8;
        o_undef   = 1'b0;
        case (op_t'(i_op))
            OP_DP:    o_imm_src = IMM_DP8;
            OP_MEM:   o_imm_src = IMM_MEM12;
            OP_BR:    o_imm_src = IMM_BR24;
            OP_UNDEF: o_undef   = 1'b1;
            default:  o_undef   = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, single-outstanding imem request, IR with valid/ready to decode.
// Optional FETCH_PC_PLUS8_EN adds the registered R15 read value id_pc_plus8.
module instr_fetch_unit
    import core_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              id_ready,
    output logic              id_valid,
    output logic [23:0]       id_inst,
    output logic [1:0]        id_imm_src,
    output logic [3:0]        id_cond,
    output logic [1:0]        id_op,
    output logic [ADDR_W-1:0] id_pc,
`ifdef FETCH_PC_PLUS8_EN
    output logic [ADDR_W-1:0] id_pc_plus8,
`endif
    output logic              id_undef
);

    localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(INSTR_BYTES);
    localparam logic [ADDR_W-1:0] PC_MASK  = ~ADDR_W'(INSTR_BYTES - 1);
    localparam logic [ADDR_W-1:0] PC_RESET = RESET_PC & PC_MASK;

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_id_pc;
    logic [31:0]       r_ir;
    logic              r_id_valid;
    logic              r_req_valid;
    logic              r_drop;
`ifdef FETCH_PC_PLUS8_EN
    logic [ADDR_W-1:0] r_pc_plus8;
`endif

    logic              w_accept;
    logic [1:0]        w_imm_src;
    logic              w_undef;
    logic              w_unused_ir;

    assign w_accept = (r_state == REQ) && r_req_valid && imem_req_ready;

    // Redirect wins over normal sequencing; a request already in flight
    // (or accepted this cycle) must have its response swallowed via r_drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= REQ;
            r_pc        <= PC_RESET;
            r_id_pc     <= PC_RESET;
            r_ir        <= 32'h0;
            r_id_valid  <= 1'b0;
            r_req_valid <= 1'b0;
            r_drop      <= 1'b0;
`ifdef FETCH_PC_PLUS8_EN
            r_pc_plus8  <= PC_RESET + ADDR_W'(2 * INSTR_BYTES);
`endif
        end else if (redirect) begin
            r_pc       <= redirect_pc & PC_MASK;
            r_id_valid <= 1'b0;
            if (w_accept || (r_state == WAIT && !imem_rsp_valid)) begin
                r_state     <= WAIT;
                r_drop      <= 1'b1;
                r_req_valid <= 1'b0;
            end else begin
                r_state     <= REQ;
                r_drop      <= 1'b0;
                r_req_valid <= 1'b1;
            end
        end else begin
            case (r_state)
                REQ: begin
                    if (w_accept) begin
                        r_state     <= WAIT;
                        r_req_valid <= 1'b0;
                    end else begin
                        r_req_valid <= 1'b1;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        if (r_drop) begin
                            r_drop      <= 1'b0;
                            r_state     <= REQ;
                            r_req_valid <= 1'b1;
                        end else begin
                            r_ir       <= imem_rdata;
                            r_id_pc    <= r_pc;
                            r_id_valid <= 1'b1;
                            r_pc       <= r_pc + PC_STEP;
`ifdef FETCH_PC_PLUS8_EN
                            r_pc_plus8 <= r_pc + ADDR_W'(2 * INSTR_BYTES);
`endif
                            r_state    <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (id_ready) begin
                        r_id_valid  <= 1'b0;
                        r_state     <= REQ;
                        r_req_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= REQ;
                    r_req_valid <= 1'b0;
                end
            endcase
        end
    end

    imm_src_decode u_imm_src_decode (
        .i_op      (r_ir[27:26]),
        .o_imm_src (w_imm_src),
        .o_undef   (w_undef)
    );

    // IR[25:24] has no consumer in this stage.
    assign w_unused_ir = ^r_ir[25:24];

    assign imem_req_valid = r_req_valid;
    assign imem_addr      = r_pc & PC_MASK;
    assign id_valid       = r_id_valid;
    assign id_inst        = r_ir[23:0];
    assign id_cond        = r_ir[31:28];
    assign id_op          = r_ir[27:26];
    assign id_pc          = r_id_pc;
    assign id_imm_src     = w_imm_src;
    assign id_undef       = w_undef;
`ifdef FETCH_PC_PLUS8_EN
    assign id_pc_plus8    = r_pc_plus8;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit with a latency-programmable memory responder.
module tb_instr_fetch_unit;

    localparam int unsigned ADDR_W      = 32;
    localparam logic [31:0] TB_RESET_PC = 32'hFFFF_FFFC;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    logic              clk            = 1'b0;
    logic              rst_n          = 1'b0;
    logic              imem_req_valid;
    logic              imem_req_ready = 1'b1;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rsp_valid = 1'b0;
    logic [31:0]       imem_rdata     = 32'h0;
    logic              redirect       = 1'b0;
    logic [ADDR_W-1:0] redirect_pc    = '0;
    logic              id_ready       = 1'b0;
    logic              id_valid;
    logic [23:0]       id_inst;
    logic [1:0]        id_imm_src;
    logic [3:0]        id_cond;
    logic [1:0]        id_op;
    logic [ADDR_W-1:0] id_pc;
    logic              id_undef;
`ifdef FETCH_PC_PLUS8_EN
    logic [ADDR_W-1:0] id_pc_plus8;
`endif

    exp_t        sb[$];
    logic [31:0] mem [logic [31:0]];
    int          mem_lat = 0;
    int          n_vec   = 0;
    int          n_err   = 0;

    instr_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(TB_RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rdata     (imem_rdata),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_inst        (id_inst),
        .id_imm_src     (id_imm_src),
        .id_cond        (id_cond),
        .id_op          (id_op),
        .id_pc          (id_pc),
`ifdef FETCH_PC_PLUS8_EN
        .id_pc_plus8    (id_pc_plus8),
`endif
        .id_undef       (id_undef)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h1234_0000 ^ a;
    endfunction

    function automatic logic [1:0] exp_imm(input logic [31:0] w);
        return (w[27:26] == 2'b11) ? 2'b00 : w[27:26];
    endfunction

    // Memory: note acceptance at the clock edge, answer mem_lat cycles later on a falling edge.
    initial begin : mem_model
        logic        acc;
        logic [31:0] acc_addr;
        logic [31:0] a;
        bit          busy;
        int          cd;
        busy = 0; cd = 0; a = '0;
        forever begin
            @(posedge clk);
            acc      = rst_n && imem_req_valid && imem_req_ready;
            acc_addr = imem_addr;
            @(negedge clk);
            imem_rsp_valid = 1'b0;
            if (!rst_n) begin
                busy = 0;
            end else begin
                if (acc) begin
                    busy = 1; cd = mem_lat; a = acc_addr;
                end else if (busy) begin
                    cd--;
                end
                if (busy && cd <= 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rdata     = mem_word(a);
                    busy           = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic expect_fetch(input logic [31:0] a, input logic [31:0] w);
        mem[a] = w;
        sb.push_back('{pc: a, word: w});
    endtask

    task automatic wait_and_check(input string name, input int stall);
        int   t;
        exp_t e;
        t = 0;
        while (!id_valid && t < 30) begin
            @(negedge clk);
            t++;
        end
        n_vec++;
        if (id_valid !== 1'b1) begin
            n_err++;
            $display("FAIL %s_valid: got id_valid=%b need 1 within 30 cycles", name, id_valid);
            return;
        end
        n_vec++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL %s_sb: got unexpected instruction pc=%h need none", name, id_pc);
            return;
        end
        e = sb.pop_front();
        n_vec++;
        if (id_pc !== e.pc) begin
            n_err++;
            $display("FAIL %s_pc: got %h need %h", name, id_pc, e.pc);
        end
        n_vec++;
        if ({id_cond, id_op, id_inst, id_imm_src, id_undef} !==
            {e.word[31:28], e.word[27:26], e.word[23:0], exp_imm(e.word), (e.word[27:26] == 2'b11)}) begin
            n_err++;
            $display("FAIL %s_fields: got cond=%h op=%b inst=%h imm=%b undef=%b need word %h",
                     name, id_cond, id_op, id_inst, id_imm_src, id_undef, e.word);
        end
`ifdef FETCH_PC_PLUS8_EN
        n_vec++;
        if (id_pc_plus8 !== e.pc + 32'd8) begin
            n_err++;
            $display("FAIL %s_pc8: got %h need %h", name, id_pc_plus8, e.pc + 32'd8);
        end
`endif
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            n_vec++;
            if ({id_valid, imem_req_valid, id_inst, id_pc} !== {1'b1, 1'b0, e.word[23:0], e.pc}) begin
                n_err++;
                $display("FAIL %s_stall%0d: got valid=%b req=%b inst=%h pc=%h need 1 0 %h %h",
                         name, i, id_valid, imem_req_valid, id_inst, id_pc, e.word[23:0], e.pc);
            end
        end
        id_ready = 1'b1;
        @(negedge clk);
        id_ready = 1'b0;
    endtask

    task automatic check_next_addr(input string name, input logic [31:0] exp_addr);
        int t;
        t = 0;
        while (!imem_req_valid && t < 30) begin
            @(negedge clk);
            t++;
        end
        n_vec++;
        if (imem_req_valid !== 1'b1 || imem_addr !== exp_addr) begin
            n_err++;
            $display("FAIL %s: got req_valid=%b addr=%h need 1 %h", name, imem_req_valid, imem_addr, exp_addr);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({imem_req_valid, id_valid, id_inst, id_imm_src, id_cond, id_op, id_undef, id_pc, imem_addr} !==
            {1'b0, 1'b0, 24'h0, 2'b00, 4'h0, 2'b00, 1'b0, TB_RESET_PC, TB_RESET_PC}) begin
            n_err++;
            $display("FAIL reset_state: got req=%b valid=%b inst=%h imm=%b cond=%h op=%b undef=%b pc=%h addr=%h need zeros pc/addr=%h",
                     imem_req_valid, id_valid, id_inst, id_imm_src, id_cond, id_op, id_undef, id_pc, imem_addr, TB_RESET_PC);
        end
`ifdef FETCH_PC_PLUS8_EN
        n_vec++;
        if (id_pc_plus8 !== TB_RESET_PC + 32'd8) begin
            n_err++;
            $display("FAIL reset_pc8: got %h need %h", id_pc_plus8, TB_RESET_PC + 32'd8);
        end
`endif
        #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_decode_wrap();
        expect_fetch(TB_RESET_PC, 32'hE3A0_1005);
        expect_fetch(32'h0,       32'hE591_2008);
        expect_fetch(32'h4,       32'hEA00_0002);
        expect_fetch(32'h8,       32'hEC00_0000);
        wait_and_check("wrap_dp", 0);
        check_next_addr("wrap_next_addr", 32'h0);
        wait_and_check("mem12", 0);
        check_next_addr("next_addr_4", 32'h4);
        wait_and_check("br24", 0);
        wait_and_check("undef", 0);
    endtask

    task automatic test_stall();
        expect_fetch(32'hC, 32'hD5AB_CDEF);
        wait_and_check("stall", 5);
    endtask

    task automatic test_redirect_wait();
        int t;
        mem[32'h10] = 32'hFFFF_FFFF;
        mem_lat = 2;
        expect_fetch(32'h100, 32'hE3A0_2001);
        t = 0;
        while (!imem_req_valid && t < 30) begin @(negedge clk); t++; end
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h103;
        @(negedge clk);
        redirect = 1'b0;
        t = 0;
        while (!imem_req_valid && t < 30) begin
            n_vec++;
            if (id_valid !== 1'b0) begin
                n_err++;
                $display("FAIL redir_wait_valid: got id_valid=%b need 0", id_valid);
            end
            @(negedge clk);
            t++;
        end
        check_next_addr("redir_wait_addr", 32'h100);
        wait_and_check("redir_wait_fetch", 0);
    endtask

    task automatic test_redirect_req();
        int t;
        mem[32'h104] = 32'hFFFF_FFFF;
        mem_lat = 1;
        expect_fetch(32'h300, 32'hE591_0004);
        t = 0;
        while (!imem_req_valid && t < 30) begin @(negedge clk); t++; end
        redirect = 1'b1; redirect_pc = 32'h300;
        @(negedge clk);
        redirect = 1'b0;
        n_vec++;
        if ({imem_req_valid, id_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL redir_req_wait: got req=%b valid=%b need 0 0", imem_req_valid, id_valid);
        end
        check_next_addr("redir_req_addr", 32'h300);
        wait_and_check("redir_req_fetch", 0);
    endtask

    task automatic test_redirect_rsp();
        int t;
        mem[32'h304] = 32'hFFFF_FFFF;
        mem_lat = 0;
        expect_fetch(32'h400, 32'hEA00_0010);
        t = 0;
        while (!imem_req_valid && t < 30) begin @(negedge clk); t++; end
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h400;
        @(negedge clk);
        redirect = 1'b0;
        n_vec++;
        if ({imem_req_valid, id_valid, imem_addr} !== {1'b1, 1'b0, 32'h400}) begin
            n_err++;
            $display("FAIL redir_rsp: got req=%b valid=%b addr=%h need 1 0 00000400", imem_req_valid, id_valid, imem_addr);
        end
        wait_and_check("redir_rsp_fetch", 0);
    endtask

    task automatic test_back_to_back();
        int   cyc, last, got;
        exp_t e;
        mem_lat = 0;
        for (int i = 0; i < 4; i++)
            expect_fetch(32'h404 + 32'(4 * i), {4'hA, 2'(i), 2'b00, 24'h0ABC00 + 24'(i)});
        id_ready = 1'b1;
        cyc = 0; last = -1; got = 0;
        while (got < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (id_valid) begin
                e = sb.pop_front();
                n_vec++;
                if ({id_pc, id_cond, id_op, id_inst, id_imm_src, id_undef} !==
                    {e.pc, e.word[31:28], e.word[27:26], e.word[23:0], exp_imm(e.word), (e.word[27:26] == 2'b11)}) begin
                    n_err++;
                    $display("FAIL b2b_%0d: got pc=%h op=%b inst=%h imm=%b undef=%b need pc=%h word=%h",
                             got, id_pc, id_op, id_inst, id_imm_src, id_undef, e.pc, e.word);
                end
                if (last >= 0) begin
                    n_vec++;
                    if (cyc - last != 3) begin
                        n_err++;
                        $display("FAIL b2b_gap_%0d: got %0d cycles need 3", got, cyc - last);
                    end
                end
                last = cyc;
                got++;
            end
        end
        id_ready = 1'b0;
        n_vec++;
        if (got != 4) begin
            n_err++;
            $display("FAIL b2b_count: got %0d instructions need 4", got);
        end
    endtask

    task automatic test_reset_mid();
        int t;
        mem_lat = 5;
        t = 0;
        while (!imem_req_valid && t < 30) begin @(negedge clk); t++; end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({imem_req_valid, id_valid, id_inst, id_imm_src, id_cond, id_op, id_undef, id_pc, imem_addr} !==
            {1'b0, 1'b0, 24'h0, 2'b00, 4'h0, 2'b00, 1'b0, TB_RESET_PC, TB_RESET_PC}) begin
            n_err++;
            $display("FAIL async_reset: got req=%b valid=%b inst=%h imm=%b cond=%h op=%b undef=%b pc=%h addr=%h need zeros pc/addr=%h",
                     imem_req_valid, id_valid, id_inst, id_imm_src, id_cond, id_op, id_undef, id_pc, imem_addr, TB_RESET_PC);
        end
        @(negedge clk);
        #1 rst_n = 1'b1;
        n_vec++;
        if ({imem_req_valid, imem_addr} !== {1'b0, TB_RESET_PC}) begin
            n_err++;
            $display("FAIL post_reset_addr: got req=%b addr=%h need 0 %h", imem_req_valid, imem_addr, TB_RESET_PC);
        end
        mem_lat = 0;
        expect_fetch(TB_RESET_PC, 32'hE591_2008);
        wait_and_check("post_reset_fetch", 0);
    endtask

    initial begin : main
        test_reset();
        test_decode_wrap();
        test_stall();
        test_redirect_wait();
        test_redirect_req();
        test_redirect_rsp();
        test_back_to_back();
        test_reset_mid();
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d pending entries need 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
